bridge_sym_packer: RTL and testbench
====================================

Name: bridge_sym_packer

Overview:
Downstream neighbour of the bridge: consumes the bridge's 2-bit symbol stream and packs symbols LSB-first into wider words. Completed words are buffered in a small FIFO and presented to the next stage under a valid/ready handshake. Single clock domain (posedge clk); synchronous active-high reset.

Parameters:
SYM_W, 2, width of one input symbol (matches bridge e/f width)
SYMS_PER_WORD, 4, symbols packed per output word (>=2)
FIFO_DEPTH, 4, output word FIFO entries (power of 2, >=2)

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous reset, active-high
in_valid  input  1  input symbol valid
in_ready  output  1  block can accept a symbol this cycle
in_sym  input  SYM_W  input symbol
in_last  input  1  final symbol of a packet; forces flush of the partial word
out_valid  output  1  out_word/out_cnt/out_last valid
out_ready  input  1  downstream accepts the word this cycle
out_word  output  SYM_W*SYMS_PER_WORD  packed word, symbol 0 in bits [SYM_W-1:0]
out_cnt  output  $clog2(SYMS_PER_WORD+1)  number of valid symbols in out_word (1..SYMS_PER_WORD)
out_last  output  1  word closes a packet

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset: while rst=1 at a posedge, the accumulator is cleared (sym count 0, data 0) and the FIFO is emptied (rd/wr pointers 0). in_ready=0 while rst is high; out_valid=0, out_word=0, out_cnt=0, out_last=0 after reset. An in-flight partial word or buffered word is discarded by reset; no output is produced for it.
- Input handshake: a symbol transfers when in_valid && in_ready at a posedge. in_ready = !rst && !fifo_full. A pop in the same cycle does not raise in_ready; full means full.
- Accumulate: an accepted symbol is written to slot acc_cnt; acc_cnt increments.
- Word close: on accept, if acc_cnt+1 == SYMS_PER_WORD or in_last=1, the word (including the current symbol) is pushed to the FIFO that same edge. out_cnt = acc_cnt+1. out_last = in_last. Unused upper slots are zero. The accumulator is cleared to 0 on the same edge.
- in_last on the SYMS_PER_WORD-th symbol gives one full word with out_last=1; no empty word follows.
- in_last held with in_valid=0 has no effect.
- FIFO: FIFO_DEPTH entries; pointers wrap modulo FIFO_DEPTH with an extra wrap bit for full/empty. out_valid = !empty. Outputs are driven from the head entry (registered storage). Pop when out_valid && out_ready. Simultaneous push and pop on a non-full, non-empty FIFO keeps occupancy unchanged.
- Latency: a word closed at edge N has out_valid=1 after edge N (visible in cycle N+1) when the FIFO was empty. Throughput is 1 symbol/cycle in and 1 word/cycle out.
- out_word/out_cnt/out_last must hold stable while out_valid=1 and out_ready=0.
- out_ready asserted while out_valid=0 is ignored.

Optional Feature:
PACKER_PARITY_EN: when defined, adds output port out_par (1 bit) = XOR of all bits of out_word, i.e. even parity over the head word. It is stored in the FIFO with the word and is 0 after reset. When not defined, the port and its storage are absent; all other behaviour is identical.

Test Plan:
- Reset then 4 symbols 1,2,3,0 back-to-back, out_ready=1 -> one word out_word=8'h39, out_cnt=4, out_last=0, out_valid high 1 cycle after the 4th accept.
- Symbols 3,1 with in_last on the 2nd -> out_word=8'h07, out_cnt=2, out_last=1; next packet starts at slot 0.
- out_ready=0, stream 16 symbols -> 4 words fill the FIFO, in_ready drops to 0 after the 16th accept. Raise out_ready -> words drain in order and in_ready returns to 1 once a pop occurs.
- Full FIFO with out_ready=1 and in_valid=1 in the same cycle -> pop occurs, no symbol accepted that cycle, occupancy 3 afterwards.
- Assert rst after 2 symbols accepted and with 1 word buffered -> out_valid=0 next cycle. A subsequent 4-symbol word packs from slot 0 with no stale data.
- With PACKER_PARITY_EN, word 8'h39 -> out_par=0; word 8'h07 -> out_par=1.

Source files
------------

// File: rtl/bridge_sym_packer.sv
`default_nettype none
// ============================================================================
// Module   : bridge_sym_packer
// Brief    : Packs SYM_W-bit symbols LSB-first into words and buffers them in a
//            small FIFO with a valid/ready output. Optional macro
//            PACKER_PARITY_EN adds an even-parity bit (out_par) per word.
// Revision : 1.0 - initial release
// ============================================================================
module bridge_sym_packer #(
    parameter int SYM_W         = 2,
    parameter int SYMS_PER_WORD = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [SYM_W-1:0]                     in_sym,
    input  logic                                 in_last,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [SYM_W*SYMS_PER_WORD-1:0]       out_word,
    output logic [$clog2(SYMS_PER_WORD+1)-1:0]   out_cnt,
`ifdef PACKER_PARITY_EN
    output logic                                 out_par,
`endif
    output logic                                 out_last
);

    localparam int CW = $clog2(SYMS_PER_WORD + 1);
    localparam int WW = SYM_W * SYMS_PER_WORD;
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [CW-1:0] r_acc_cnt;
    logic [WW-1:0] r_acc_data;
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;

    logic [WW-1:0] r_mem_word [FIFO_DEPTH];
    logic [CW-1:0] r_mem_cnt  [FIFO_DEPTH];
    logic          r_mem_last [FIFO_DEPTH];
`ifdef PACKER_PARITY_EN
    logic          r_mem_par  [FIFO_DEPTH];
`endif

    logic          w_full;
    logic          w_empty;
    logic          w_accept;
    logic          w_close;
    logic          w_pop;
    logic [WW-1:0] w_word;

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign in_ready = !rst && !w_full;
    assign w_accept = in_valid && in_ready;
    assign w_close  = w_accept && ((r_acc_cnt == CW'(SYMS_PER_WORD - 1)) || in_last);
    assign w_pop    = !w_empty && out_ready;

    // Current symbol merged into its slot; upper slots stay zero because the
    // accumulator is cleared whenever a word closes.
    always_comb begin
        w_word = r_acc_data;
        for (int i = 0; i < SYMS_PER_WORD; i++) begin
            if (r_acc_cnt == CW'(i)) begin
                w_word[i*SYM_W +: SYM_W] = in_sym;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_cnt  <= '0;
            r_acc_data <= '0;
        end else if (w_close) begin
            r_acc_cnt  <= '0;
            r_acc_data <= '0;
        end else if (w_accept) begin
            r_acc_cnt  <= r_acc_cnt + CW'(1);
            r_acc_data <= w_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_close) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_close) begin
            r_mem_word[r_wr_ptr[AW-1:0]] <= w_word;
            r_mem_cnt[r_wr_ptr[AW-1:0]]  <= r_acc_cnt + CW'(1);
            r_mem_last[r_wr_ptr[AW-1:0]] <= in_last;
`ifdef PACKER_PARITY_EN
            r_mem_par[r_wr_ptr[AW-1:0]]  <= ^w_word;
`endif
        end
    end

    assign out_valid = !w_empty;
    assign out_word  = w_empty ? '0   : r_mem_word[r_rd_ptr[AW-1:0]];
    assign out_cnt   = w_empty ? '0   : r_mem_cnt[r_rd_ptr[AW-1:0]];
    assign out_last  = w_empty ? 1'b0 : r_mem_last[r_rd_ptr[AW-1:0]];
`ifdef PACKER_PARITY_EN
    assign out_par   = w_empty ? 1'b0 : r_mem_par[r_rd_ptr[AW-1:0]];
`endif

endmodule
`default_nettype wire

// File: tb/tb_bridge_sym_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bridge_sym_packer
// Brief    : Directed self-checking bench for bridge_sym_packer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bridge_sym_packer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] in_sym = 2'd0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_word;
    logic [2:0] out_cnt;
    logic       out_last;
`ifdef PACKER_PARITY_EN
    logic       out_par;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bridge_sym_packer #(.SYM_W(2), .SYMS_PER_WORD(4), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sym    (in_sym),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_cnt   (out_cnt),
`ifdef PACKER_PARITY_EN
        .out_par   (out_par),
`endif
        .out_last  (out_last)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] s, input logic l);
        in_valid = 1'b1;
        in_sym   = s;
        in_last  = l;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        step();
        step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if ({out_word, out_cnt, out_last} !== 12'h000) begin errors++; $display("FAIL reset_outputs got %h/%0d/%b exp 0", out_word, out_cnt, out_last); end
`ifdef PACKER_PARITY_EN
        checks++; if (out_par !== 1'b0) begin errors++; $display("FAIL reset_par got %b exp 0", out_par); end
`endif
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
        // out_ready high with nothing buffered must not disturb the FIFO
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_full_word();
        logic [1:0] syms [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid sym %0d got %b exp 0", i, out_valid); end
            send(syms[i], 1'b0);
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_valid got %b exp 1", out_valid); end
        checks++; if (out_word !== 8'h39) begin errors++; $display("FAIL full_word got %h exp 39", out_word); end
        checks++; if (out_cnt !== 3'd4) begin errors++; $display("FAIL full_cnt got %0d exp 4", out_cnt); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL full_last got %b exp 0", out_last); end
`ifdef PACKER_PARITY_EN
        checks++; if (out_par !== 1'b0) begin errors++; $display("FAIL full_par got %b exp 0", out_par); end
`endif
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_pop got %b exp 0", out_valid); end
    endtask

    task automatic test_last();
        out_ready = 1'b1;
        send(2'd3, 1'b0);
        // in_last without in_valid must not close the partial word
        in_last = 1'b1;
        step();
        in_last = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL last_idle got %b exp 0", out_valid); end
        send(2'd1, 1'b1);
        checks++; if (out_word !== 8'h07) begin errors++; $display("FAIL last_word got %h exp 07", out_word); end
        checks++; if (out_cnt !== 3'd2) begin errors++; $display("FAIL last_cnt got %0d exp 2", out_cnt); end
        checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL last_flag got %b exp 1", out_last); end
`ifdef PACKER_PARITY_EN
        checks++; if (out_par !== 1'b1) begin errors++; $display("FAIL last_par got %b exp 1", out_par); end
`endif
        step();
        send(2'd2, 1'b1);
        checks++; if ({out_word, out_cnt, out_last} !== {8'h02, 3'd1, 1'b1}) begin errors++; $display("FAIL last_slot0 got %h/%0d/%b exp 02/1/1", out_word, out_cnt, out_last); end
        step();
        // in_last on the 4th symbol: one full word, no trailing empty word
        for (int i = 0; i < 4; i++) send(2'(i), i == 3);
        checks++; if ({out_word, out_cnt, out_last} !== {8'hE4, 3'd4, 1'b1}) begin errors++; $display("FAIL last_full got %h/%0d/%b exp e4/4/1", out_word, out_cnt, out_last); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL last_no_empty got %b exp 0", out_valid); end
    endtask

    task automatic test_fill_drain();
        logic [7:0] exp_w [4];
        logic [1:0] s;
        out_ready = 1'b0;
        for (int w = 0; w < 4; w++) exp_w[w] = 8'h00;
        for (int i = 0; i < 16; i++) begin
            s = 2'((i / 4 + i * 3) % 4);
            exp_w[i/4][(i%4)*2 +: 2] = s;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready sym %0d got %b exp 1", i, in_ready); end
            send(s, 1'b0);
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_full got %b exp 0", in_ready); end
        checks++; if (out_word !== exp_w[0]) begin errors++; $display("FAIL fill_hold got %h exp %h", out_word, exp_w[0]); end
        step();
        checks++; if (out_word !== exp_w[0] || out_valid !== 1'b1) begin errors++; $display("FAIL fill_stable got %h/%b exp %h/1", out_word, out_valid, exp_w[0]); end
        // full FIFO: pop and offered symbol on the same edge; only the pop happens
        in_valid = 1'b1;
        in_sym = 2'd3;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_pop_ready got %b exp 0", in_ready); end
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL after_pop_ready got %b exp 1", in_ready); end
        out_ready = 1'b1;
        for (int w = 1; w < 4; w++) begin
            checks++; if (out_valid !== 1'b1 || out_word !== exp_w[w] || out_cnt !== 3'd4) begin errors++; $display("FAIL drain_%0d got %b/%h/%0d exp 1/%h/4", w, out_valid, out_word, out_cnt, exp_w[w]); end
            step();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0 (occupancy not 3)", out_valid); end
        for (int i = 0; i < 4; i++) send(2'd1, 1'b0);
        checks++; if (out_word !== 8'h55 || out_cnt !== 3'd4) begin errors++; $display("FAIL no_accept_when_full got %h/%0d exp 55/4", out_word, out_cnt); end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(2'd2, 1'b0);
        send(2'd3, 1'b0);
        send(2'd3, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_word !== 8'hAA) begin errors++; $display("FAIL mid_buffered got %b/%h exp 1/aa", out_valid, out_word); end
        rst = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b exp 0", out_valid); end
        rst = 1'b0;
        out_ready = 1'b1;
        send(2'd0, 1'b0);
        send(2'd0, 1'b0);
        send(2'd0, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale_close got %b exp 0", out_valid); end
        send(2'd1, 1'b0);
        checks++; if (out_word !== 8'h40 || out_cnt !== 3'd4 || out_last !== 1'b0) begin errors++; $display("FAIL mid_clean_word got %h/%0d/%b exp 40/4/0", out_word, out_cnt, out_last); end
        step();
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_last();
        test_fill_drain();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
